// File: rtl/riscv16_pkg.sv
// riscv16_pkg
// Shared definitions for the 16-bit multicycle core control path.
// Contents:
//   - Major opcode constants (instr[6:0])
//   - Controller state encoding (state_t)
//   - alu_op encodings driven toward the ALU decoder
//   - trap_cause encodings
//   - is_legal_opcode() helper used by DECODE
package riscv16_pkg;

  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE        = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
  localparam logic [1:0] CAUSE_BUS_TIMEOUT = 2'b10;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_I_ALU, OP_R_ALU, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles a memory request has waited for ready.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - restart the count at zero (takes priority over count_en)
//   count_en   - request pending with ready low this cycle
//   expired    - the current cycle is the MEM_TIMEOUT-th request cycle
// Parameter:
//   MEM_TIMEOUT - request cycles allowed before the controller traps
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The count equals the number of already-elapsed wait cycles, so it
  // reaches LAST during the MEM_TIMEOUT-th cycle of the request.
  assign expired = (count_q == LAST);

  // Saturate at LAST so the count never wraps back below the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a 16-bit multicycle core: FETCH, DECODE, EXEC, MEM, WB
// and a sticky TRAP state. All control outputs are combinational in the
// current state, the instruction register and the ready inputs.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   instr[15:0]                  - instruction register (opcode in [6:0])
//   imem_ready, dmem_ready       - memory handshakes
//   branch_taken                 - ALU compare result for a branch in EXEC
//   imem_req, ir_we              - fetch request / IR load strobe
//   dmem_req, dmem_we            - data request / store qualifier
//   alu_src_imm, alu_op[1:0]     - ALU operand-B select / operation class
//   reg_we, wb_sel               - register write / write-back source
//   pc_we, pc_src                - PC update / next-PC select
//   trap, trap_cause[1:0]        - sticky trap flag and its cause
//   instret[15:0]                - retired-instruction counter
// Parameter:
//   MEM_TIMEOUT - request cycles allowed before a bus-timeout trap
// Configuration macro:
//   ILLEGAL_TRAP_EN - illegal opcodes trap (cause 01); otherwise they
//                     retire as NOPs.
module multicycle_controller
  import riscv16_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [15:0] instret
);

  state_t      state_q, state_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [15:0] instret_q, instret_d;
  logic        retire;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;
  logic [6:0]  opcode;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[15:7];

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count_en(timer_en),
    .expired (timer_expired)
  );

  // Every entry into FETCH or MEM is a state change, so clearing on any
  // transition restarts the timer for each new request. Only a pending
  // request with its own ready low advances it.
  always_comb begin
    timer_clear = (state_d != state_q);
    timer_en    = ((state_q == ST_FETCH) && !imem_ready) ||
                  ((state_q == ST_MEM)   && !dmem_ready);
  end

  // Next-state and output decode. A ready in the last allowed cycle wins
  // over the timeout because it is tested first. Outputs are forced low
  // while reset is held, since the reset state (FETCH) would otherwise
  // already be requesting.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_OP_ADD;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_BUS_TIMEOUT;
        end
      end

      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
`else
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
`endif
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            alu_op  = ALU_OP_SUB;
            pc_we   = 1'b1;
            pc_src  = branch_taken;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OP_I_ALU: begin
            alu_src_imm = 1'b1;
            alu_op      = ALU_OP_FUNCT;
            state_d     = ST_WB;
          end
          OP_R_ALU: begin
            alu_op  = ALU_OP_FUNCT;
            state_d = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_imm = 1'b1;
            state_d     = ST_MEM;
          end
          default: begin
            state_d = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timer_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_BUS_TIMEOUT;
        end
      end

      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (opcode == OP_LOAD);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (rst) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_OP_ADD;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
      trap        = 1'b0;
      retire      = 1'b0;
    end
  end

  // Retire is seen in the count one cycle later; 16-bit wrap is natural.
  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      trap_cause_q <= CAUSE_NONE;
      instret_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
    end
  end

  assign trap_cause = trap_cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller built with MEM_TIMEOUT=4.
// Walks each instruction class cycle by cycle, then the fetch and data
// timeouts, ready arriving in the last allowed cycle, and reset during a
// data wait. Expected output words are hand-built from the bit masks below.
// Honors ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_src_imm;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic        wb_sel;
  logic        pc_we;
  logic        pc_src;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [15:0] instret;
  logic [15:0] outs;

  int testsRun;
  int testsFailed;

  // Bit masks of the packed output word.
  localparam logic [15:0] O_IMEM  = 16'h2000;
  localparam logic [15:0] O_IRWE  = 16'h1000;
  localparam logic [15:0] O_DREQ  = 16'h0800;
  localparam logic [15:0] O_DWE   = 16'h0400;
  localparam logic [15:0] O_IMM   = 16'h0200;
  localparam logic [15:0] O_FUNCT = 16'h0100;
  localparam logic [15:0] O_SUB   = 16'h0080;
  localparam logic [15:0] O_RWE   = 16'h0040;
  localparam logic [15:0] O_WBS   = 16'h0020;
  localparam logic [15:0] O_PCWE  = 16'h0010;
  localparam logic [15:0] O_PCSRC = 16'h0008;
  localparam logic [15:0] O_TRAP  = 16'h0004;
  localparam logic [15:0] O_C_BUS = 16'h0002;
  localparam logic [15:0] O_C_ILL = 16'h0001;
  localparam logic [15:0] O_NONE  = 16'h0000;

  multicycle_controller #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .branch_taken(branch_taken),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  assign outs = {2'b00, imem_req, ir_we, dmem_req, dmem_we, alu_src_imm,
                 alu_op, reg_we, wb_sel, pc_we, pc_src, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] i, input logic ir,
                               input logic dr, input logic bt);
    instr        = i;
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
  endtask

  // Drives one cycle's inputs just after a falling edge, checks the
  // combinational outputs, then moves on to the next falling edge.
  task automatic cycleCheck(input string tag, input logic [15:0] i,
                            input logic ir, input logic dr, input logic bt,
                            input logic [15:0] expected);
    applyStimulus(i, ir, dr, bt);
    #1;
    checkOutput(tag, outs, expected);
    @(negedge clk);
  endtask

  // Holds reset for two cycles with both readies high; everything,
  // including instret, must read zero while reset is asserted.
  task automatic doReset(input string tag);
    rst = 1'b1;
    applyStimulus(16'h0013, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput({tag, "_outs"}, outs, O_NONE);
    checkOutput({tag, "_instret"}, instret, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    doReset("reset0");

    // I-ALU, zero-wait: 4 cycles.
    cycleCheck("alu_fetch",  16'h0013, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("alu_decode", 16'h0013, 1, 1, 0, O_NONE);
    cycleCheck("alu_exec",   16'h0013, 1, 1, 0, O_IMM | O_FUNCT);
    cycleCheck("alu_wb",     16'h0013, 0, 0, 0, O_RWE | O_PCWE);
    checkOutput("alu_instret", instret, 16'd1);

    // Branch taken and not taken: 3 cycles each.
    cycleCheck("bt_fetch",   16'h0063, 1, 0, 1, O_IMEM | O_IRWE);
    cycleCheck("bt_decode",  16'h0063, 0, 0, 1, O_NONE);
    cycleCheck("bt_exec",    16'h0063, 0, 0, 1, O_SUB | O_PCWE | O_PCSRC);
    checkOutput("bt_instret", instret, 16'd2);
    cycleCheck("bn_fetch",   16'h0063, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("bn_decode",  16'h0063, 0, 0, 0, O_NONE);
    cycleCheck("bn_exec",    16'h0063, 0, 0, 0, O_SUB | O_PCWE);
    checkOutput("bn_instret", instret, 16'd3);

    // R-ALU: register operand, funct decode.
    cycleCheck("r_fetch",    16'h0033, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("r_decode",   16'h0033, 0, 0, 0, O_NONE);
    cycleCheck("r_exec",     16'h0033, 0, 0, 0, O_FUNCT);
    cycleCheck("r_wb",       16'h0033, 0, 0, 0, O_RWE | O_PCWE);

    // Store, zero-wait: 4 cycles, retires from MEM.
    cycleCheck("st_fetch",   16'h0023, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("st_decode",  16'h0023, 0, 0, 0, O_NONE);
    cycleCheck("st_exec",    16'h0023, 0, 0, 0, O_IMM);
    cycleCheck("st_mem",     16'h0023, 0, 1, 0, O_DREQ | O_DWE | O_PCWE);
    checkOutput("st_instret", instret, 16'd5);

    // Load with three wait cycles: ready lands in the 4th (last allowed)
    // request cycle, total 8 cycles. imem_ready high in MEM is ignored.
    cycleCheck("ld_fetch",   16'h0003, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("ld_decode",  16'h0003, 0, 0, 0, O_NONE);
    cycleCheck("ld_exec",    16'h0003, 0, 0, 0, O_IMM);
    for (int k = 0; k < 3; k++) begin
      cycleCheck("ld_mem_wait", 16'h0003, 1, 0, 0, O_DREQ);
    end
    cycleCheck("ld_mem_done", 16'h0003, 0, 1, 0, O_DREQ);
    cycleCheck("ld_wb",      16'h0003, 0, 0, 0, O_RWE | O_WBS | O_PCWE);
    checkOutput("ld_instret", instret, 16'd6);

    // Illegal opcode 0x7F.
    cycleCheck("ill_fetch",  16'h007F, 1, 0, 0, O_IMEM | O_IRWE);
`ifdef ILLEGAL_TRAP_EN
    cycleCheck("ill_decode", 16'h007F, 0, 0, 0, O_NONE);
    cycleCheck("ill_trap",   16'h007F, 1, 1, 0, O_TRAP | O_C_ILL);
    checkOutput("ill_instret", instret, 16'd6);
`else
    cycleCheck("ill_decode", 16'h007F, 0, 0, 0, O_PCWE);
    checkOutput("ill_instret", instret, 16'd7);
    cycleCheck("ill_refetch", 16'h007F, 0, 0, 0, O_IMEM);
`endif
    doReset("reset1");

    // Fetch timeout: four request cycles without ready, then sticky trap.
    for (int k = 0; k < 4; k++) begin
      cycleCheck("fto_fetch", 16'h0013, 0, 1, 0, O_IMEM);
    end
    cycleCheck("fto_trap",   16'h0013, 1, 1, 0, O_TRAP | O_C_BUS);
    cycleCheck("fto_sticky", 16'h0013, 1, 1, 0, O_TRAP | O_C_BUS);
    doReset("reset2");

    // Fetch ready in the 4th request cycle completes normally.
    for (int k = 0; k < 3; k++) begin
      cycleCheck("flast_wait", 16'h0013, 0, 0, 0, O_IMEM);
    end
    cycleCheck("flast_fetch",  16'h0013, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("flast_decode", 16'h0013, 0, 0, 0, O_NONE);
    cycleCheck("flast_exec",   16'h0013, 0, 0, 0, O_IMM | O_FUNCT);
    cycleCheck("flast_wb",     16'h0013, 0, 0, 0, O_RWE | O_PCWE);
    checkOutput("flast_instret", instret, 16'd1);

    // Reset during a data wait abandons the load with no retire.
    cycleCheck("rmid_fetch",  16'h0003, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("rmid_decode", 16'h0003, 0, 0, 0, O_NONE);
    cycleCheck("rmid_exec",   16'h0003, 0, 0, 0, O_IMM);
    cycleCheck("rmid_mem",    16'h0003, 0, 0, 0, O_DREQ);
    cycleCheck("rmid_mem",    16'h0003, 0, 0, 0, O_DREQ);
    doReset("reset3");
    cycleCheck("post_reset_fetch", 16'h0003, 0, 1, 0, O_IMEM);

    // Data timeout: four MEM cycles without ready, then bus trap.
    cycleCheck("dto_fetch",  16'h0003, 1, 0, 0, O_IMEM | O_IRWE);
    cycleCheck("dto_decode", 16'h0003, 0, 0, 0, O_NONE);
    cycleCheck("dto_exec",   16'h0003, 0, 0, 0, O_IMM);
    for (int k = 0; k < 4; k++) begin
      cycleCheck("dto_mem", 16'h0003, 0, 0, 0, O_DREQ);
    end
    cycleCheck("dto_trap",   16'h0003, 0, 1, 0, O_TRAP | O_C_BUS);
    checkOutput("dto_instret", instret, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, maximum cycles a memory request may wait for ready before a bus-error trap.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instr  input  16  current instruction-register contents; opcode in bits [6:0].
REQ-005 imem_ready  input  1  instruction memory has the requested word valid this cycle.
REQ-006 dmem_ready  input  1  data memory has completed the access this cycle.
REQ-007 branch_taken  input  1  ALU compare result for the branch currently in EXEC.
REQ-008 imem_req / ir_we  output  1 each  instruction fetch request / instruction-register load strobe.
REQ-009 dmem_req / dmem_we  output  1 each  data access request / write (store) qualifier.
REQ-010 alu_src_imm  output  1  ALU operand B comes from the immediate generator.
REQ-011 alu_op  output  2  00 add, 01 sub (branch compare), 10 decode by funct.
REQ-012 reg_we / wb_sel  output  1 each  register write enable / write-back source (0 ALU, 1 memory).
REQ-013 pc_we / pc_src  output  1 each  PC update strobe / next-PC select (0 PC+2, 1 branch target).
REQ-014 trap / trap_cause  output  1 / 2  sticky trap flag / cause (00 none, 01 illegal opcode, 10 bus timeout).
REQ-015 instret  output  16  retired-instruction counter.

Function
REQ-016 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs SHALL be combinational in state, instr and ready inputs; all outputs not listed for a state SHALL be 0.
REQ-017 FETCH: imem_req=1; on imem_ready=1 assert ir_we that cycle and go to DECODE; else stay.
REQ-018 DECODE: single cycle; legal opcodes 0010011 (I-ALU), 0110011 (R-ALU), 0000011 (load), 0100011 (store), 1100011 (branch) go to EXEC.
REQ-019 EXEC: alu_src_imm=1 for I-ALU, load and store; alu_op=01 for branch, 10 for I-ALU/R-ALU, 00 otherwise.
REQ-020 EXEC branch: pc_we=1, pc_src=branch_taken, go to FETCH (retire); ALU ops go to WB; load/store go to MEM.
REQ-021 MEM: dmem_req=1, dmem_we=1 for store; on dmem_ready, store asserts pc_we (pc_src=0) and goes to FETCH (retire); load goes to WB; else stay.
REQ-022 WB: reg_we=1, wb_sel=1 for load and 0 otherwise, pc_we=1, pc_src=0, go to FETCH (retire).
REQ-023 Latency: ALU op 4 cycles, branch 3, store 4, load 5 with zero-wait memory; each wait cycle adds one.
REQ-024 instret SHALL increment by 1 in the cycle after each retire and wrap 0xFFFF to 0x0000.
REQ-025 Wait timer SHALL clear on entry to FETCH or MEM and count cycles with ready low; if ready is still low in the MEM_TIMEOUT-th request cycle, go to TRAP with trap_cause=10.
REQ-026 Ready arriving in the MEM_TIMEOUT-th cycle SHALL complete normally (ready has priority over timeout).
REQ-027 TRAP: trap=1, trap_cause held, no request/strobe outputs; exits only by reset.
REQ-028 Ready inputs asserted outside their matching state SHALL be ignored.

Reset
REQ-029 While rst=1, state SHALL be FETCH, timer 0, instret 0, trap_cause 00, and every output 0 (imem_req gated).
REQ-030 Reset asserted mid-access SHALL abandon the access immediately with no retire.
REQ-031 The first imem_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-032 Macro ILLEGAL_TRAP_EN defined: illegal opcode in DECODE goes to TRAP with trap_cause=01.
REQ-033 Macro ILLEGAL_TRAP_EN undefined: illegal opcode is a NOP: DECODE asserts pc_we (pc_src=0), retires, returns to FETCH; trap_cause 01 is never produced.

Structure
REQ-034 Shared package riscv16_pkg SHALL hold the opcode constants, the state encoding, the alu_op encodings and the trap_cause encodings.
REQ-035 One sub-module, mem_wait_timer (clear, count-enable, MEM_TIMEOUT parameter, expired flag), SHALL implement the wait timer.

Verification
REQ-036 Reset, instr=0x0013 (I-ALU), imem_ready=1 -> states FETCH, DECODE, EXEC, WB; reg_we=1 and pc_we=1 in cycle 4; instret=1.
REQ-037 Branch 0x0063, branch_taken=1 -> pc_we=1 and pc_src=1 in EXEC; no reg_we; next state FETCH.
REQ-038 Load 0x0003, dmem_ready low for 3 cycles -> dmem_req held 4 cycles, dmem_we=0; WB with wb_sel=1; total latency 8 cycles.
REQ-039 MEM_TIMEOUT=4, imem_ready never asserted -> TRAP after 4 FETCH cycles, trap_cause=10; ready arriving in cycle 4 instead -> normal DECODE.
REQ-040 Opcode 0x007F: with ILLEGAL_TRAP_EN -> TRAP, trap_cause=01; without -> pc_we=1 in DECODE, instret increments.
REQ-041 rst asserted during a MEM wait, then released -> all outputs 0 during reset, instret=0, imem_req=1 in the first cycle after release.
